// File: rtl/dro_pkg.sv
// Shared constants and types for the DRO (destructive readout) cell model.
package dro_pkg;

  localparam int DRO_SETUP_CYC_DEF = 3;
  localparam int DRO_HOLD_CYC_DEF  = 2;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2
  } viol_kind_t;

  function automatic int dro_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dro_if.sv
// Bundles the toggle-encoded DRO signals; viol_cnt exists only when DRO_VIOL_CNT_EN is defined.
interface dro_if;

  logic        set;
  logic        reset;
  logic        out;
  logic        state;
  logic        viol_setup;
  logic        viol_hold;
`ifdef DRO_VIOL_CNT_EN
  logic [15:0] viol_cnt;

  modport master (output set, reset, input out, state, viol_setup, viol_hold, viol_cnt);
  modport slave  (input set, reset, output out, state, viol_setup, viol_hold, viol_cnt);
`else
  modport master (output set, reset, input out, state, viol_setup, viol_hold);
  modport slave  (input set, reset, output out, state, viol_setup, viol_hold);
`endif

endinterface

// File: rtl/dro_toggle_det.sv
// Converts a toggle-encoded level into a pulse: high when the level differs from last edge's.
module dro_toggle_det (
  input  logic clk,
  input  logic lvl_i,
  output logic pulse_o
);

  logic hist_q;

  // Loaded every edge, reset included, so the first edge after reset sees no pulse.
  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    hist_q <= lvl_i;
  end

  assign pulse_o = lvl_i ^ hist_q;

endmodule

// File: rtl/dro.sv
// DRO cell: toggle-encoded set/reset in, toggle-encoded readout out, setup/hold checking.
// Optional saturating violation counter enabled by defining DRO_VIOL_CNT_EN.
module dro
  import dro_pkg::*;
#(
  parameter int SETUP_CYC = DRO_SETUP_CYC_DEF,
  parameter int HOLD_CYC  = DRO_HOLD_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        reset,
  output logic        out,
  output logic        state,
  output logic        viol_setup,
  output logic        viol_hold
`ifdef DRO_VIOL_CNT_EN
  ,
  output logic [15:0] viol_cnt
`endif
);

  localparam int SAT_CYC = dro_max(SETUP_CYC, HOLD_CYC);
  localparam int CW      = $clog2(SAT_CYC + 1);

  typedef logic [CW-1:0] ivl_t;
  localparam ivl_t SAT = ivl_t'(SAT_CYC);

  function automatic ivl_t sat_inc(input ivl_t v);
    return (v == SAT) ? v : v + ivl_t'(1);
  endfunction

  logic       set_p, reset_p;
  logic       out_q, out_d;
  logic       state_q, state_d;
  ivl_t       since_set_q, since_set_d;
  ivl_t       since_rst_q, since_rst_d;
  viol_kind_t viol_d;
  logic       viol_setup_q, viol_hold_q;

  dro_toggle_det u_set_det (
    .clk     (clk),
    .lvl_i   (set),
    .pulse_o (set_p)
  );

  dro_toggle_det u_reset_det (
    .clk     (clk),
    .lvl_i   (reset),
    .pulse_o (reset_p)
  );

  // Interval counters hold "edges since last pulse": 1 on the edge after the pulse.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    out_d       = out_q;
    state_d     = state_q;
    since_set_d = sat_inc(since_set_q);
    since_rst_d = sat_inc(since_rst_q);
    viol_d      = NONE;

    if (set_p) begin
      state_d     = 1'b1;
      since_set_d = ivl_t'(1);
    end

    // Readout uses the old state; a simultaneous set wins the stored bit.
    if (reset_p) begin
      if (state_q) out_d = ~out_q;
      if (!set_p) state_d = 1'b0;
      since_rst_d = ivl_t'(1);
    end

    if (reset_p && (set_p || since_set_q < ivl_t'(SETUP_CYC))) begin
      viol_d = SETUP;
    end else if (set_p && since_rst_q < ivl_t'(HOLD_CYC)) begin
      viol_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= 1'b0;
      state_q      <= 1'b0;
      since_set_q  <= SAT;
      since_rst_q  <= SAT;
      viol_setup_q <= 1'b0;
      viol_hold_q  <= 1'b0;
    end else begin
      out_q        <= out_d;
      state_q      <= state_d;
      since_set_q  <= since_set_d;
      since_rst_q  <= since_rst_d;
      viol_setup_q <= (viol_d == SETUP);
      viol_hold_q  <= (viol_d == HOLD);
    end
  end

  assign out        = out_q;
  assign state      = state_q;
  assign viol_setup = viol_setup_q;
  assign viol_hold  = viol_hold_q;

`ifdef DRO_VIOL_CNT_EN
  logic [15:0] viol_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      viol_cnt_q <= '0;
    end else if (viol_d != NONE && viol_cnt_q != 16'hFFFF) begin
      viol_cnt_q <= viol_cnt_q + 16'd1;
    end
  end

  assign viol_cnt = viol_cnt_q;
`endif

endmodule

// File: tb/tb_dro.sv
// Self-checking bench for dro: directed table, hand-written corner sequences and a
// randomized run against an edge-index reference model.
module tb_dro;

  localparam int SETUP = 3;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dro_if bus ();

  dro #(.SETUP_CYC(SETUP), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .set        (bus.set),
    .reset      (bus.reset),
    .out        (bus.out),
    .state      (bus.state),
    .viol_setup (bus.viol_setup),
    .viol_hold  (bus.viol_hold)
`ifdef DRO_VIOL_CNT_EN
    ,
    .viol_cnt   (bus.viol_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remembers the edge index of the last pulses and the stored bit.
  int edge_n;
  int last_set, last_rst;
  bit m_state, m_out, m_vs, m_vh;
  int m_cnt;

  task automatic model_reset();
    edge_n   = 0;
    last_set = -1000;
    last_rst = -1000;
    m_state  = 1'b0;
    m_out    = 1'b0;
    m_vs     = 1'b0;
    m_vh     = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic model_step(input bit ts, input bit tr);
    edge_n++;
    m_vs = tr && (ts || (edge_n - last_set) < SETUP);
    m_vh = ts && !tr && (edge_n - last_rst) < HOLD;
    if (tr && m_state) m_out = ~m_out;
    if (ts)      m_state = 1'b1;
    else if (tr) m_state = 1'b0;
    if (ts) last_set = edge_n;
    if (tr) last_rst = edge_n;
    if ((m_vs || m_vh) && m_cnt < 65535) m_cnt++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/out"},   16'(bus.out),        16'(m_out));
    check({tag, "/state"}, 16'(bus.state),      16'(m_state));
    check({tag, "/vs"},    16'(bus.viol_setup), 16'(m_vs));
    check({tag, "/vh"},    16'(bus.viol_hold),  16'(m_vh));
`ifdef DRO_VIOL_CNT_EN
    check({tag, "/cnt"},   bus.viol_cnt,        16'(m_cnt));
`endif
  endtask

  // Called at a negedge: apply toggles, let one rising edge pass, return at the next negedge.
  task automatic drive_edge(input bit ts, input bit tr);
    bus.set   = bus.set ^ ts;
    bus.reset = bus.reset ^ tr;
    model_step(ts, tr);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Input levels move randomly while rst is high; none of that may look like a pulse afterwards.
  task automatic do_reset();
    rst       = 1'b1;
    bus.set   = 1'($urandom);
    bus.reset = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.set   = 1'($urandom);
    bus.reset = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  typedef struct {
    bit ts, tr;
    bit out, state, vs, vh;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bus.set   = 1'b0;
    bus.reset = 1'b0;
    model_reset();

    // Expected values worked out by hand for SETUP=3, HOLD=2 starting from reset.
    tbl[0]  = '{ts:0, tr:1, out:0, state:0, vs:0, vh:0}; // readout of "0"
    tbl[1]  = '{ts:0, tr:0, out:0, state:0, vs:0, vh:0};
    tbl[2]  = '{ts:1, tr:0, out:0, state:1, vs:0, vh:0}; // 2 edges after reset: legal
    tbl[3]  = '{ts:0, tr:0, out:0, state:1, vs:0, vh:0};
    tbl[4]  = '{ts:0, tr:0, out:0, state:1, vs:0, vh:0};
    tbl[5]  = '{ts:0, tr:1, out:1, state:0, vs:0, vh:0}; // 3 edges after set: legal
    tbl[6]  = '{ts:1, tr:1, out:1, state:1, vs:1, vh:0}; // simultaneous, state 0
    tbl[7]  = '{ts:0, tr:0, out:1, state:1, vs:0, vh:0};
    tbl[8]  = '{ts:0, tr:1, out:0, state:0, vs:1, vh:0}; // 2 edges after set
    tbl[9]  = '{ts:1, tr:0, out:0, state:1, vs:0, vh:1}; // 1 edge after reset
    tbl[10] = '{ts:1, tr:1, out:1, state:1, vs:1, vh:0}; // simultaneous, state 1
    tbl[11] = '{ts:0, tr:0, out:1, state:1, vs:0, vh:0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive_edge(tbl[i].ts, tbl[i].tr);
      check($sformatf("tbl%0d/out", i),   16'(bus.out),        16'(tbl[i].out));
      check($sformatf("tbl%0d/state", i), 16'(bus.state),      16'(tbl[i].state));
      check($sformatf("tbl%0d/vs", i),    16'(bus.viol_setup), 16'(tbl[i].vs));
      check($sformatf("tbl%0d/vh", i),    16'(bus.viol_hold),  16'(tbl[i].vh));
    end

    // Set at cycle 10, reset at cycle 20: clean write then readout of "1".
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      drive_edge(c == 10, c == 20);
      if (c >= 10 && c <= 19) check("seq028/state_hi", 16'(bus.state), 16'd1);
      check_model("seq028");
    end
    check("seq028/out", 16'(bus.out), 16'd1);
    check("seq028/state", 16'(bus.state), 16'd0);
    check("seq028/viol", 16'({bus.viol_setup, bus.viol_hold}), 16'd0);

    // Set at cycle 10, reset at cycle 12: readout still happens, setup flagged once.
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      drive_edge(c == 10, c == 12);
      check("seq030/vs", 16'(bus.viol_setup), 16'(c == 12));
      if (c == 12) check("seq030/out", 16'(bus.out), 16'd1);
    end

    // Reset at cycle 30, set at cycle 31: hold flagged, bit still written.
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      drive_edge(c == 31, c == 30);
      check("seq032/vh", 16'(bus.viol_hold), 16'(c == 31));
    end
    check("seq032/state", 16'(bus.state), 16'd1);

    // rst mid-operation discards the stored bit; levels moved during rst are no pulses.
    drive_edge(1'b0, 1'b0);
    do_reset();
    check("midrst/state", 16'(bus.state), 16'd0);
    drive_edge(1'b0, 1'b0);
    check("midrst/state_idle", 16'(bus.state), 16'd0);
    check("midrst/out_idle", 16'(bus.out), 16'd0);

`ifdef DRO_VIOL_CNT_EN
    do_reset();
    drive_edge(1'b1, 1'b1);
    drive_edge(1'b0, 1'b1);
    drive_edge(1'b1, 1'b0);
    check("seq033/cnt3", bus.viol_cnt, 16'd3);
    do_reset();
    check("seq033/cnt_clr", bus.viol_cnt, 16'd0);
`endif

    // Randomized run with occasional resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive_edge($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        check_model("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dro.md
DRO -- requirements
Module: dro

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 3: minimum clk cycles from a set pulse to a later reset pulse.
REQ-002 SHALL have parameter HOLD_CYC, default 2: minimum clk cycles from a reset pulse to a later set pulse.
REQ-003 SHALL have port clk, input, 1 bit: single clock; every register samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port set, input, 1 bit: toggle-encoded write; each level change is one set pulse.
REQ-006 SHALL have port reset, input, 1 bit: toggle-encoded readout/clear; each level change is one reset pulse.
REQ-007 SHALL have port out, output, 1 bit: toggle-encoded readout; one level change per "1" read.
REQ-008 SHALL have port state, output, 1 bit: stored flux bit.
REQ-009 SHALL have port viol_setup, output, 1 bit: one-cycle pulse on a setup violation.
REQ-010 SHALL have port viol_hold, output, 1 bit: one-cycle pulse on a hold violation.
REQ-011 SHALL have port viol_cnt, output, 16 bits, only when DRO_VIOL_CNT_EN is defined: saturating count of all violations.

Function
REQ-012 SHALL detect a pulse at rising edge k when the input differs from its value registered at edge k-1; set and reset are synchronous to clk.
REQ-013 SHALL set state to 1 at edge k on a set pulse alone; a set while state=1 changes nothing.
REQ-014 SHALL, on a reset pulse alone at edge k with state=1, toggle out and clear state at edge k (latency 1 edge).
REQ-015 SHALL, on a reset pulse alone with state=0, leave out and state unchanged (destructive readout of "0").
REQ-016 SHALL, on simultaneous set and reset pulses at edge k, read the old state (toggle out if state=1), leave state=1 afterwards, and pulse viol_setup.
REQ-017 SHALL pulse viol_setup at edge k when a reset pulse arrives fewer than SETUP_CYC edges after the last set pulse (interval 0 included).
REQ-018 SHALL pulse viol_hold at edge k when a set pulse arrives fewer than HOLD_CYC edges after the last reset pulse.
REQ-019 SHALL let violations flag only; the data behaviour of REQ-013..016 is unchanged.
REQ-020 SHALL track interval counters that saturate at max(SETUP_CYC, HOLD_CYC) so there is no wrap-around.
REQ-021 SHALL treat the interval counters as saturated immediately after reset, so the first pulses never flag a violation.

Reset
REQ-022 SHALL, while rst=1 at an edge, force out=0, state=0, viol_setup=0, viol_hold=0 and viol_cnt=0, set both interval counters to saturated, and load the input-history registers with the current set/reset levels.
REQ-023 SHALL ignore pulses at an edge where rst=1; rst mid-operation discards the stored bit.

Configuration
REQ-024 SHALL, with DRO_VIOL_CNT_EN defined, add viol_cnt, which increments by 1 per edge with viol_setup or viol_hold and saturates at 16'hFFFF.
REQ-025 SHALL, without DRO_VIOL_CNT_EN, omit the viol_cnt port and counter; all other behaviour is identical.

Structure
REQ-026 SHALL keep DRO_SETUP_CYC_DEF, DRO_HOLD_CYC_DEF and a viol_kind_t enum (NONE, SETUP, HOLD) in package dro_pkg.
REQ-027 SHALL implement the toggle-to-pulse converter as sub-module dro_toggle_det (input-history register plus XOR), instantiated once for set and once for reset.

Verification
REQ-028 SHALL cover: rst, then set toggles at cycle 10 and reset toggles at cycle 20 -> state 1 at cycles 10..19, out 0->1 at cycle 20, state 0, no violation.
REQ-029 SHALL cover: reset toggles with state=0 -> out unchanged, no violation.
REQ-030 SHALL cover: set at cycle 10, reset at cycle 12 (SETUP_CYC=3) -> out toggles at cycle 12 and viol_setup pulses at cycle 12 only.
REQ-031 SHALL cover: set and reset in the same cycle with state=0 -> out unchanged, state=1, viol_setup=1.
REQ-032 SHALL cover: reset at cycle 30, set at cycle 31 -> viol_hold pulses at cycle 31 and state=1.
REQ-033 SHALL cover: with DRO_VIOL_CNT_EN, 3 violations -> viol_cnt=3, and rst clears it to 0.
